// File: rtl/anastk_pkg.sv
// Shared types, default constants and arithmetic helpers for the analog stick conditioner.
package anastk_pkg;

  typedef logic signed [9:0] pos_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    RETURN = 2'd2
  } axis_state_t;

  localparam int unsigned DELT_D   = 15;
  localparam int unsigned DMAX_D   = 30;
  localparam int unsigned LIM_D    = 120;
  localparam int unsigned DZONE_D  = 8;
  localparam int unsigned SLEW_D   = 32;
  localparam int unsigned CENTER_D = 127;
  localparam int unsigned STEP_W   = 6;

  // Clamp a position to +/-lim.
  function automatic pos_t sat_lim(input pos_t v, input pos_t lim);
    pos_t r;
    r = v;
    if (v > lim)  r = lim;
    if (v < -lim) r = -lim;
    return r;
  endfunction

  // Move cur toward tgt by at most mx, landing exactly on tgt when close enough.
  function automatic pos_t step_toward(input pos_t cur, input pos_t tgt, input pos_t mx);
    pos_t diff;
    pos_t r;
    diff = tgt - cur;
    r    = tgt;
    if (diff > mx)  r = cur + mx;
    if (diff < -mx) r = cur - mx;
    return r;
  endfunction

  // Sign-extend an 8-bit two's complement byte to position width.
  function automatic pos_t sext8(input logic [7:0] b);
    return {{2{b[7]}}, b};
  endfunction

endpackage

// File: rtl/anastk_axis.sv
// One axis of the stick conditioner: position, step size and drive state, updated on frame tick.
module anastk_axis
  import anastk_pkg::*;
#(
  parameter int unsigned DELT  = DELT_D,
  parameter int unsigned DMAX  = DMAX_D,
  parameter int unsigned LIM   = LIM_D,
  parameter int unsigned DZONE = DZONE_D,
  parameter int unsigned SLEW  = SLEW_D
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_tick,
  input  logic       i_mode,
  input  pos_t       i_tgt,
  input  logic       i_plus,
  input  logic       i_minus,
  output logic [7:0] o_pos_c
);

  localparam pos_t LIM_P  = pos_t'(LIM);
  localparam pos_t DZ_P   = pos_t'(DZONE);
  localparam pos_t SLEW_P = pos_t'(SLEW);
  localparam pos_t DELT_P = pos_t'(DELT);
  localparam logic [STEP_W-1:0] DELT_S = STEP_W'(DELT);
  localparam logic [STEP_W-1:0] DMAX_S = STEP_W'(DMAX);

  pos_t              r_pos, w_pos_nxt, w_tgt;
  logic [STEP_W-1:0] r_step, w_step_nxt, w_step_eff;
  axis_state_t       r_state, w_state_nxt;
  logic              r_dir, w_dir_nxt;

  // State register; r_dir = 1 means the last drive was toward negative.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pos   <= '0;
      r_step  <= DELT_S;
      r_state <= IDLE;
      r_dir   <= 1'b0;
    end else begin
      r_pos   <= w_pos_nxt;
      r_step  <= w_step_nxt;
      r_state <= w_state_nxt;
      r_dir   <= w_dir_nxt;
    end
  end

  // Next position/step/state; everything holds unless this is a tick cycle.
  always_comb begin
    w_pos_nxt   = r_pos;
    w_step_nxt  = r_step;
    w_state_nxt = r_state;
    w_dir_nxt   = r_dir;
    w_tgt       = '0;
    w_step_eff  = r_step;
    if (i_tick) begin
      if (!i_mode) begin
        w_tgt = sat_lim(i_tgt, LIM_P);
        if ((w_tgt <= DZ_P) && (w_tgt >= -DZ_P)) w_tgt = '0;
        w_pos_nxt   = sat_lim(step_toward(r_pos, w_tgt, SLEW_P), LIM_P);
        w_step_nxt  = DELT_S;
        w_state_nxt = (w_tgt != '0) ? DRIVE : ((w_pos_nxt == '0) ? IDLE : RETURN);
      end else if (i_plus ^ i_minus) begin
        if ((r_state == DRIVE) && (r_dir != i_minus)) w_step_eff = DELT_S;
        w_pos_nxt   = i_minus ? sat_lim(r_pos - pos_t'(w_step_eff), LIM_P)
                              : sat_lim(r_pos + pos_t'(w_step_eff), LIM_P);
        w_step_nxt  = (w_step_eff >= DMAX_S) ? DMAX_S : w_step_eff + STEP_W'(1);
        w_dir_nxt   = i_minus;
        w_state_nxt = DRIVE;
      end else begin
        w_step_nxt  = DELT_S;
        w_pos_nxt   = sat_lim(step_toward(r_pos, '0, DELT_P), LIM_P);
        w_state_nxt = (w_pos_nxt == '0) ? IDLE : RETURN;
      end
    end
  end

  assign o_pos_c = w_pos_nxt[7:0];

endmodule

// File: rtl/anastk_cond.sv
// Per-player analog stick conditioner: frame tick detect, optional calibration, pot output registers.
// Build option: define ANASTK_CAL_EN to add the i_cal port and offset capture.
module anastk_cond
  import anastk_pkg::*;
#(
  parameter int unsigned DELT   = DELT_D,
  parameter int unsigned DMAX   = DMAX_D,
  parameter int unsigned LIM    = LIM_D,
  parameter int unsigned DZONE  = DZONE_D,
  parameter int unsigned SLEW   = SLEW_D,
  parameter int unsigned CENTER = CENTER_D
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [8:0]  i_pv,
  input  logic        i_mode,
  input  logic [15:0] i_ana,
  input  logic        i_lf,
  input  logic        i_rg,
  input  logic        i_up,
  input  logic        i_dw,
`ifdef ANASTK_CAL_EN
  input  logic        i_cal,
`endif
  output logic [7:0]  o_ax,
  output logic [7:0]  o_ay,
  output logic        o_frame
);

  localparam logic [7:0] CTR8 = 8'(CENTER);

  logic [8:0] r_ppv;
  logic       w_tick;
  logic [7:0] w_offx, w_offy;
  pos_t       w_tx, w_ty;
  logic [7:0] w_posx, w_posy;
  logic [7:0] r_ax, r_ay;
  logic       r_frame;

  assign w_tick = (r_ppv != '0) && (i_pv == '0);

`ifdef ANASTK_CAL_EN
  logic       r_cal_d;
  logic [7:0] r_offx, r_offy;

  // CAL rising edge captures the current stick bytes as the rest offsets.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cal_d <= 1'b0;
      r_offx  <= '0;
      r_offy  <= '0;
    end else begin
      r_cal_d <= i_cal;
      if (i_cal && !r_cal_d) begin
        r_offx <= i_ana[7:0];
        r_offy <= i_ana[15:8];
      end
    end
  end

  assign w_offx = r_offx;
  assign w_offy = r_offy;
`else
  assign w_offx = '0;
  assign w_offy = '0;
`endif

  // Positive position means left/up, so the stick reading is negated.
  assign w_tx = -(sext8(i_ana[7:0])  - sext8(w_offx));
  assign w_ty = -(sext8(i_ana[15:8]) - sext8(w_offy));

  anastk_axis #(
    .DELT(DELT), .DMAX(DMAX), .LIM(LIM), .DZONE(DZONE), .SLEW(SLEW)
  ) u_axis_x (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_tick  (w_tick),
    .i_mode  (i_mode),
    .i_tgt   (w_tx),
    .i_plus  (i_lf),
    .i_minus (i_rg),
    .o_pos_c (w_posx)
  );

  anastk_axis #(
    .DELT(DELT), .DMAX(DMAX), .LIM(LIM), .DZONE(DZONE), .SLEW(SLEW)
  ) u_axis_y (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_tick  (w_tick),
    .i_mode  (i_mode),
    .i_tgt   (w_ty),
    .i_plus  (i_up),
    .i_minus (i_dw),
    .o_pos_c (w_posy)
  );

  // Previous PV, frame pulse and pot outputs, all refreshed together on tick.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ppv   <= '0;
      r_frame <= 1'b0;
      r_ax    <= CTR8;
      r_ay    <= CTR8;
    end else begin
      r_ppv   <= i_pv;
      r_frame <= w_tick;
      if (w_tick) begin
        r_ax <= w_posx + CTR8;
        r_ay <= w_posy + CTR8;
      end
    end
  end

  assign o_ax    = r_ax;
  assign o_ay    = r_ay;
  assign o_frame = r_frame;

endmodule

// File: tb/tb_anastk_cond.sv
// Bench for anastk_cond: behavioural reference model plus directed literal checks and random stimulus.
module tb_anastk_cond;

  localparam int DELT = 15, DMAX = 30, LIM = 120, DZONE = 8, SLEW = 32, CENTER = 127;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [8:0]  pv = '0;
  logic        mode = 1'b0;
  logic [15:0] ana = '0;
  logic        lf = 1'b0, rg = 1'b0, up = 1'b0, dw = 1'b0;
  logic        cal = 1'b0;
  logic [7:0]  ax, ay;
  logic        frame;

  anastk_cond dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_pv    (pv),
    .i_mode  (mode),
    .i_ana   (ana),
    .i_lf    (lf),
    .i_rg    (rg),
    .i_up    (up),
    .i_dw    (dw),
`ifdef ANASTK_CAL_EN
    .i_cal   (cal),
`endif
    .o_ax    (ax),
    .o_ay    (ay),
    .o_frame (frame)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int m_pos[2], m_step[2], m_dir[2], m_off[2];
  bit m_drive[2];
  int m_ppv;
  bit m_cald;
  int exp_ax = CENTER, exp_ay = CENTER;
  bit exp_frame = 1'b0;
  int m_t, m_d, m_sd;
  bit m_plus, m_minus;

  function automatic int sat(input int v);
    if (v > LIM) return LIM;
    if (v < -LIM) return -LIM;
    return v;
  endfunction

  function automatic int sbyte(input logic [7:0] b);
    return (int'(b) >= 128) ? int'(b) - 256 : int'(b);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int a = 0; a < 2; a++) begin
        m_pos[a] = 0; m_step[a] = DELT; m_dir[a] = 0; m_off[a] = 0; m_drive[a] = 1'b0;
      end
      m_ppv = 0; m_cald = 1'b0;
      exp_ax = CENTER; exp_ay = CENTER; exp_frame = 1'b0;
    end else begin
      if (m_ppv != 0 && pv == 9'd0) begin
        for (int a = 0; a < 2; a++) begin
          m_plus  = (a == 0) ? lf : up;
          m_minus = (a == 0) ? rg : dw;
          if (!mode) begin
            m_t = -(sbyte((a == 0) ? ana[7:0] : ana[15:8]) - m_off[a]);
            m_t = sat(m_t);
            if (m_t <= DZONE && m_t >= -DZONE) m_t = 0;
            m_d = m_t - m_pos[a];
            if (m_d > SLEW) m_pos[a] = m_pos[a] + SLEW;
            else if (m_d < -SLEW) m_pos[a] = m_pos[a] - SLEW;
            else m_pos[a] = m_t;
            m_drive[a] = (m_t != 0);
            m_step[a] = DELT;
          end else if (m_plus != m_minus) begin
            m_sd = m_plus ? 1 : -1;
            if (m_drive[a] && m_sd != m_dir[a]) m_step[a] = DELT;
            m_pos[a] = sat(m_pos[a] + m_sd * m_step[a]);
            m_step[a] = (m_step[a] + 1 > DMAX) ? DMAX : m_step[a] + 1;
            m_drive[a] = 1'b1;
            m_dir[a] = m_sd;
          end else begin
            m_step[a] = DELT;
            m_drive[a] = 1'b0;
            if (m_pos[a] > DELT) m_pos[a] = m_pos[a] - DELT;
            else if (m_pos[a] < -DELT) m_pos[a] = m_pos[a] + DELT;
            else m_pos[a] = 0;
          end
        end
        exp_ax = (m_pos[0] + CENTER) & 255;
        exp_ay = (m_pos[1] + CENTER) & 255;
        exp_frame = 1'b1;
      end else begin
        exp_frame = 1'b0;
      end
      m_ppv = int'(pv);
`ifdef ANASTK_CAL_EN
      if (cal && !m_cald) begin
        m_off[0] = sbyte(ana[7:0]);
        m_off[1] = sbyte(ana[15:8]);
      end
      m_cald = cal;
`endif
    end
  end

  // ---------------- checking ----------------
  int vecs = 0, errs = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    vecs++;
    if (act !== expv) begin
      errs++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // One clock: wait for the inactive edge and compare every output with the model.
  task automatic cyc();
    @(negedge clk);
    vecs++;
    if (ax !== 8'(exp_ax) || ay !== 8'(exp_ay) || frame !== exp_frame) begin
      errs++;
      $display("FAIL model t=%0t ax=%0d/%0d ay=%0d/%0d frame=%0b/%0b",
               $time, ax, exp_ax, ay, exp_ay, frame, exp_frame);
    end
  endtask

  // PV leaves 0 then returns; outputs show the tick result when this returns.
  task automatic do_tick();
    pv = 9'd5;
    cyc();
    pv = 9'd0;
    cyc();
  endtask

  int dig_up[5]  = '{142, 158, 175, 193, 212};
  int dig_rel[7] = '{197, 182, 167, 152, 137, 127, 127};
  int ana_sl[5]  = '{159, 191, 223, 247, 247};

  initial begin
    repeat (3) cyc();
    chk("rst_ax", 32'(ax), 127);
    chk("rst_ay", 32'(ay), 127);
    chk("rst_frame", 32'(frame), 0);
    rst_n = 1'b1;
    repeat (2) cyc();

    do_tick();
    chk("first_tick_frame", 32'(frame), 1);
    chk("first_tick_ax", 32'(ax), 127);
    cyc();
    chk("frame_one_cycle", 32'(frame), 0);

    // digital accelerating sweep and no-overshoot return
    mode = 1'b1; lf = 1'b1;
    for (int i = 0; i < 5; i++) begin do_tick(); chk("dig_hold_ax", 32'(ax), 32'(dig_up[i])); end
    lf = 1'b0;
    for (int i = 0; i < 7; i++) begin do_tick(); chk("dig_release_ax", 32'(ax), 32'(dig_rel[i])); end

    // analog target, deadzone, setup for both-held
    mode = 1'b0; ana = 16'h00F6;
    do_tick(); chk("ana_m10_ax", 32'(ax), 137);
    ana = 16'h0005;
    do_tick(); chk("ana_deadzone_ax", 32'(ax), 127);
    ana = 16'h00EC;
    do_tick(); chk("ana_m20_ax", 32'(ax), 147);
    mode = 1'b1; lf = 1'b1; rg = 1'b1;
    do_tick(); chk("both_held_ax1", 32'(ax), 132);
    do_tick(); chk("both_held_ax2", 32'(ax), 127);
    lf = 1'b0; rg = 1'b0;

    // analog slew to the limit
    mode = 1'b0; ana = 16'h0080;
    for (int i = 0; i < 5; i++) begin do_tick(); chk("ana_slew_ax", 32'(ax), 32'(ana_sl[i])); end
    ana = 16'h00B7;
    do_tick(); chk("ana_back_ax1", 32'(ax), 215);
    do_tick(); chk("ana_back_ax2", 32'(ax), 200);

    // asynchronous reset between ticks, then PV held at 0
    #2 rst_n = 1'b0;
    #1 chk("async_rst_ax", 32'(ax), 127);
    chk("async_rst_frame", 32'(frame), 0);
    cyc();
    #2 rst_n = 1'b1;
    ana = 16'h0000;
    repeat (10) cyc();
    chk("no_tick_pv0_frame", 32'(frame), 0);
    do_tick();
    chk("tick_after_rst_frame", 32'(frame), 1);
    chk("tick_after_rst_ax", 32'(ax), 127);

`ifdef ANASTK_CAL_EN
    ana = 16'h0010; cal = 1'b1; cyc(); cal = 1'b0; cyc();
    do_tick(); chk("cal_center_ax", 32'(ax), 127);
    ana = 16'h0030;
    do_tick(); chk("cal_offset_ax", 32'(ax), 95);
    ana = 16'h0000; cal = 1'b1; cyc(); cal = 1'b0; cyc();
    do_tick(); chk("cal_clear_ax", 32'(ax), 127);
`endif

    // digital clamp at the limit, then reversal restarts at the base step
    mode = 1'b1; lf = 1'b1;
    repeat (7) do_tick();
    chk("dig_clamp_ax", 32'(ax), 247);
    lf = 1'b0; rg = 1'b1;
    do_tick(); chk("dig_reverse_ax", 32'(ax), 232);
    rg = 1'b0; up = 1'b1;
    do_tick(); chk("dig_up_ay", 32'(ay), 142);
    up = 1'b0;

    // random stimulus against the model
    for (int i = 0; i < 4000; i++) begin
      pv = ($urandom_range(0, 2) == 0) ? 9'd0 : 9'($urandom_range(1, 511));
      if ($urandom_range(0, 7) == 0) {lf, rg, up, dw} = 4'($urandom);
      if ($urandom_range(0, 5) == 0) ana = 16'($urandom);
      if ($urandom_range(0, 60) == 0) mode = ~mode;
      cal = ($urandom_range(0, 40) == 0);
      if (i == 2000) begin
        #2 rst_n = 1'b0;
        #3 rst_n = 1'b1;
      end
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
